// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the multi-port register bank.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_N_RD      = 3;
  localparam int unsigned DEF_PC_IDX    = 15;
  localparam int unsigned DEF_PC_OFFSET = 8;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Write, read, scoreboard and status signals of the multi-port register bank.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned N_RD   = DEF_N_RD
);

  logic                     we_a;
  logic [ADDR_W-1:0]        wa_a;
  logic [DATA_W-1:0]        wd_a;
  logic                     we_b;
  logic [ADDR_W-1:0]        wa_b;
  logic [DATA_W-1:0]        wd_b;
  logic [N_RD*ADDR_W-1:0]   ra;
  logic [N_RD*DATA_W-1:0]   rd;
  logic [DATA_W-1:0]        pc;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;
  logic [(2**ADDR_W)-1:0]   busy;
  logic [N_RD-1:0]          hazard;
  logic                     collide;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra, pc, busy_set, busy_addr,
    input  rd, busy, hazard, collide
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra, pc, busy_set, busy_addr,
    output rd, busy, hazard, collide
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by load issue, cleared by load
// writeback, plus per-read-port hazard flags.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned N_RD   = DEF_N_RD,
  parameter int unsigned PC_IDX = DEF_PC_IDX,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  input  logic                       clr,
  input  logic [ADDR_W-1:0]          clr_addr,
  input  logic [N_RD*ADDR_W-1:0]     ra,
  output logic [(2**ADDR_W)-1:0]     busy,
  output logic [N_RD-1:0]            hazard
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [(2**ADDR_W)-1:0] busy_q, busy_d;

  // Set is applied after clear so a new load issued behind a retiring one stays pending.
  always_comb begin
    busy_d = busy_q;
    if (clr) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (busy_set && (busy_addr != PC_ADDR)) begin
      busy_d[busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < N_RD; i++) begin : gen_hazard
    logic [ADDR_W-1:0] addr;
    logic              retiring;
    assign addr     = ra[i*ADDR_W +: ADDR_W];
    assign retiring = (BYPASS != 0) && clr && (clr_addr == addr);
    assign hazard[i] = busy_q[addr] && (addr != PC_ADDR) && !retiring;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register bank: two write ports with B-over-A arbitration, bypassed async reads,
// a virtual PC register and a pending-load scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned N_RD      = DEF_N_RD,
  parameter int unsigned PC_IDX    = DEF_PC_IDX,
  parameter int unsigned PC_OFFSET = DEF_PC_OFFSET,
  parameter int unsigned BYPASS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_mp_if.slave bus
);

  localparam int unsigned       NREGS   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              a_ok, b_ok, wr_a, collide_d, collide_q;

  // Writes aimed at the virtual PC register are dropped and never count as a collision.
  assign a_ok      = bus.we_a && (bus.wa_a != PC_ADDR);
  assign b_ok      = bus.we_b && (bus.wa_b != PC_ADDR);
  assign collide_d = a_ok && b_ok && (bus.wa_a == bus.wa_b);
  assign wr_a      = a_ok && !collide_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_a) begin
        regs_q[bus.wa_a] <= bus.wd_a;
      end
      if (b_ok) begin
        regs_q[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide_d;
    end
  end

  assign bus.collide = collide_q;

  for (genvar i = 0; i < N_RD; i++) begin : gen_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;

    assign addr = bus.ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      word = regs_q[addr];
      if (addr == PC_ADDR) begin
        word = bus.pc + DATA_W'(PC_OFFSET);
      end else if ((BYPASS != 0) && bus.we_b && (bus.wa_b == addr)) begin
        word = bus.wd_b;
      end else if ((BYPASS != 0) && bus.we_a && (bus.wa_a == addr)) begin
        word = bus.wd_a;
      end
    end

    assign bus.rd[i*DATA_W +: DATA_W] = word;
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD),
    .PC_IDX (PC_IDX),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .busy_set  (bus.busy_set),
    .busy_addr (bus.busy_addr),
    .clr       (bus.we_b),
    .clr_addr  (bus.wa_b),
    .ra        (bus.ra),
    .busy      (bus.busy),
    .hazard    (bus.hazard)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations, then random traffic
// checked every cycle against an array-based model of the register bank.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(4), .N_RD(3)) bus ();

  reg_file_mp #(
    .DATA_W    (32),
    .ADDR_W    (4),
    .N_RD      (3),
    .PC_IDX    (15),
    .PC_OFFSET (8),
    .BYPASS    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  word_t       mregs [16];
  logic [15:0] mbusy;
  logic        mcollide;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mbusy    = '0;
    mcollide = 1'b0;
  endtask

  function automatic reg_addr_t ra_of(input int p);
    return bus.ra[p*4 +: 4];
  endfunction

  function automatic word_t rd_of(input int p);
    return bus.rd[p*32 +: 32];
  endfunction

  function automatic word_t exp_rd(input reg_addr_t a);
    if (a == 4'd15) return bus.pc + 32'd8;
    if (bus.we_b && bus.wa_b == a) return bus.wd_b;
    if (bus.we_a && bus.wa_a == a) return bus.wd_a;
    return mregs[a];
  endfunction

  // Compare every output against the model, away from the rising edge.
  task automatic settle();
    logic [2:0] exp_hz;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      reg_addr_t a;
      a = ra_of(p);
      chk($sformatf("rd%0d(ra=%0d)", p, a), 64'(rd_of(p)), 64'(exp_rd(a)));
      exp_hz[p] = mbusy[a] && (a != 4'd15) && !(bus.we_b && bus.wa_b == a);
    end
    chk("hazard", 64'(bus.hazard), 64'(exp_hz));
    chk("busy", 64'(bus.busy), 64'(mbusy));
    chk("collide", 64'(bus.collide), 64'(mcollide));
  endtask

  // Clock edge: apply the architectural effect of this cycle's inputs to the model.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      mcollide = bus.we_a && bus.we_b && bus.wa_a == bus.wa_b && bus.wa_a != 4'd15;
      if (bus.we_a && bus.wa_a != 4'd15) mregs[bus.wa_a] = bus.wd_a;
      if (bus.we_b && bus.wa_b != 4'd15) mregs[bus.wa_b] = bus.wd_b;
      if (bus.we_b) mbusy[bus.wa_b] = 1'b0;
      if (bus.busy_set && bus.busy_addr != 4'd15) mbusy[bus.busy_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.we_a = 1'b0;
    bus.we_b = 1'b0;
    bus.busy_set = 1'b0;
  endtask

  function automatic reg_addr_t rnd_addr();
    if ($urandom_range(0, 1) == 0) return reg_addr_t'($urandom_range(0, 3));
    return reg_addr_t'($urandom_range(0, 15));
  endfunction

  initial begin
    bus.we_a = 1'b0; bus.wa_a = '0; bus.wd_a = '0;
    bus.we_b = 1'b0; bus.wa_b = '0; bus.wd_b = '0;
    bus.ra = '0; bus.pc = '0; bus.busy_set = 1'b0; bus.busy_addr = '0;
    reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: reset in the middle of operation wipes registers and scoreboard.
    bus.we_a = 1'b1; bus.wa_a = 4'd2; bus.wd_a = 32'h55;
    bus.busy_set = 1'b1; bus.busy_addr = 4'd4;
    settle(); advance();
    idle();
    bus.ra = {4'd2, 4'd4, 4'd0};
    settle();
    chk("t1 busy4 before reset", 64'(bus.busy[4]), 64'd1);
    chk("t1 r2 before reset", 64'(rd_of(2)), 64'h55);
    advance();
    rst = 1'b1;
    reset_model();
    bus.pc = 32'h100;
    bus.ra = {4'd2, 4'd4, 4'd15};
    settle();
    chk("t1 rd0 pc", 64'(rd_of(0)), 64'h108);
    chk("t1 rd2 zero", 64'(rd_of(2)), 64'h0);
    chk("t1 busy zero", 64'(bus.busy), 64'h0);
    advance();
    rst = 1'b0;

    // 2: port A write with same-cycle bypass.
    bus.we_a = 1'b1; bus.wa_a = 4'd0; bus.wd_a = 32'hFF;
    bus.ra = {4'd1, 4'd0, 4'd0};
    settle();
    chk("t2 bypass rd0", 64'(rd_of(0)), 64'hFF);
    advance();
    idle();
    settle();
    chk("t2 rd0", 64'(rd_of(0)), 64'hFF);
    chk("t2 rd1", 64'(rd_of(1)), 64'hFF);
    advance();

    // 3: A/B collision on r3, B wins and collide pulses once.
    bus.we_a = 1'b1; bus.wa_a = 4'd3; bus.wd_a = 32'h11;
    bus.we_b = 1'b1; bus.wa_b = 4'd3; bus.wd_b = 32'h22;
    bus.ra = {4'd0, 4'd0, 4'd3};
    settle(); advance();
    idle();
    settle();
    chk("t3 r3", 64'(rd_of(0)), 64'h22);
    chk("t3 collide on", 64'(bus.collide), 64'd1);
    advance();
    settle();
    chk("t3 collide off", 64'(bus.collide), 64'd0);
    advance();

    // 4: scoreboard set, hazard, retire via port B.
    bus.busy_set = 1'b1; bus.busy_addr = 4'd5;
    bus.ra = {4'd0, 4'd5, 4'd0};
    settle(); advance();
    idle();
    settle();
    chk("t4 busy5 set", 64'(bus.busy[5]), 64'd1);
    chk("t4 hazard1 set", 64'(bus.hazard[1]), 64'd1);
    advance();
    bus.we_b = 1'b1; bus.wa_b = 4'd5; bus.wd_b = 32'hAB;
    settle();
    chk("t4 hazard1 masked", 64'(bus.hazard[1]), 64'd0);
    advance();
    idle();
    settle();
    chk("t4 busy5 cleared", 64'(bus.busy[5]), 64'd0);
    chk("t4 rd1", 64'(rd_of(1)), 64'hAB);
    advance();

    // 5: set and clear of the same register in one cycle; set wins.
    bus.busy_set = 1'b1; bus.busy_addr = 4'd7;
    bus.we_b = 1'b1; bus.wa_b = 4'd7; bus.wd_b = 32'h77;
    settle(); advance();
    idle();
    bus.ra = {4'd7, 4'd0, 4'd0};
    settle();
    chk("t5 busy7", 64'(bus.busy[7]), 64'd1);
    chk("t5 r7", 64'(rd_of(2)), 64'h77);
    chk("t5 hazard2", 64'(bus.hazard[2]), 64'd1);
    advance();

    // 6: writes and busy_set aimed at the virtual PC register are ignored.
    bus.we_a = 1'b1; bus.wa_a = 4'd15; bus.wd_a = 32'hDEAD;
    bus.we_b = 1'b1; bus.wa_b = 4'd15; bus.wd_b = 32'hBEEF;
    bus.busy_set = 1'b1; bus.busy_addr = 4'd15;
    bus.pc = 32'h200;
    bus.ra = {4'd0, 4'd0, 4'd15};
    settle();
    chk("t6 rd0 pc during write", 64'(rd_of(0)), 64'h208);
    advance();
    idle();
    settle();
    chk("t6 rd0 pc", 64'(rd_of(0)), 64'h208);
    chk("t6 collide", 64'(bus.collide), 64'd0);
    chk("t6 busy15", 64'(bus.busy[15]), 64'd0);
    advance();

    // PC wrap-around truncates to the data width.
    bus.pc = 32'hFFFF_FFFC;
    settle();
    chk("pc wrap", 64'(rd_of(0)), 64'h4);
    advance();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      bus.we_a = ($urandom_range(0, 1) == 1);
      bus.wa_a = rnd_addr();
      bus.wd_a = $urandom;
      bus.we_b = ($urandom_range(0, 2) == 0);
      bus.wa_b = ($urandom_range(0, 3) == 0) ? bus.wa_a : rnd_addr();
      bus.wd_b = $urandom;
      bus.ra = {rnd_addr(), rnd_addr(), rnd_addr()};
      bus.pc = $urandom;
      bus.busy_set = ($urandom_range(0, 2) == 0);
      bus.busy_addr = ($urandom_range(0, 3) == 0) ? bus.wa_b : rnd_addr();
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        reset_model();
        settle();
        advance();
        rst = 1'b0;
      end else begin
        settle();
        advance();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
